rcc_interval_arbiter: RTL and testbench

- Shares one CW-bit up-counter (the ripple-counter resource) between NREQ requesters.
- Each requester asks for an interval of len[i] clock cycles.
- The block grants the counter round-robin, clears it, runs it for exactly len[i] cycles, then pulses done with the winner's id.
- Sits between the requester logic and the shared counter; it is the only block that clears or enables that counter.

---
 rtl/rcc_pkg.sv | 14 +
 rtl/rcc_interval_arbiter_if.sv | 27 ++
 rtl/rcc_rr_pick.sv | 35 +++
 rtl/rcc_interval_arbiter.sv | 150 +++++++++++++++
 tb/tb_rcc_interval_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rcc_pkg.sv
// Shared definitions for the interval arbiter: FSM state encoding and parameter defaults.
package rcc_pkg;

    localparam int unsigned RCC_NREQ_DEF = 4;
    localparam int unsigned RCC_CW_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } rcc_state_e;

endpackage

// File: rtl/rcc_interval_arbiter_if.sv
// Requester-side bus of the interval arbiter: requests and lengths in, grant/counter/completion out.
interface rcc_interval_arbiter_if
    import rcc_pkg::*;
#(
    parameter int NREQ = RCC_NREQ_DEF,
    parameter int CW   = RCC_CW_DEF,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      q;
    logic               done;
    logic [IDW-1:0]     done_id;
    logic               aborted;

    modport master (
        output req, len,
        input  grant, busy, q, done, done_id, aborted
    );

    modport slave (
        input  req, len,
        output grant, busy, q, done, done_id, aborted
    );
endinterface

// File: rtl/rcc_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from rr_ptr+1, wrapping.
module rcc_rr_pick
    import rcc_pkg::*;
#(
    parameter int NREQ = RCC_NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic            valid_o,
    output logic [IDW-1:0]  id_o,
    output logic [NREQ-1:0] onehot_o
);

    int idx_s;

    // Scan NREQ positions after the pointer; the pointer itself is ranked last.
    always_comb begin
        valid_o  = 1'b0;
        id_o     = {IDW{1'b0}};
        onehot_o = {NREQ{1'b0}};
        idx_s    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = (int'(rr_ptr_i) + k) % NREQ;
            if (!valid_o && req_i[idx_s]) begin
                valid_o         = 1'b1;
                id_o            = idx_s[IDW-1:0];
                onehot_o[idx_s] = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/rcc_interval_arbiter.sv
// Round-robin owner of a shared CW-bit up-counter: grants it, runs it for the winner's interval,
// and reports completion (or early abort) with the winner's id.
module rcc_interval_arbiter
    import rcc_pkg::*;
#(
    parameter int NREQ = RCC_NREQ_DEF,
    parameter int CW   = RCC_CW_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    rcc_interval_arbiter_if.slave  bus
);

    rcc_state_e      state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   target_q, target_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic            aborted_q, aborted_d;

    logic            pick_valid_s;
    logic [IDW-1:0]  pick_id_s;
    logic [NREQ-1:0] pick_onehot_s;
    logic [CW-1:0]   len_sel_s;

    rcc_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid_s),
        .id_o     (pick_id_s),
        .onehot_o (pick_onehot_s)
    );

    // Interval length of the requester the picker currently selects.
    always_comb begin
        len_sel_s = {CW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id_s == i[IDW-1:0]) begin
                len_sel_s = bus.len[i*CW +: CW];
            end else begin
                len_sel_s = len_sel_s;
            end
        end
    end

    // Next-state and registered-output logic; abort wins over normal completion in RUN.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    id_d     = pick_id_s;
                    grant_d  = pick_onehot_s;
                    target_d = len_sel_s;
                    state_d  = ST_LOAD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_d = {CW{1'b0}};
                if (target_q == {CW{1'b0}}) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    aborted_d = 1'b0;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.req[id_q]) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    aborted_d = 1'b1;
                end else if (cnt_q == (target_q - CW'(1))) begin
                    cnt_d     = cnt_q + CW'(1);
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    aborted_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                rr_ptr_d = id_q;
                grant_d  = {NREQ{1'b0}};
                state_d  = ST_IDLE;
            end
            default: begin
                grant_d = {NREQ{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            id_q      <= {IDW{1'b0}};
            rr_ptr_q  <= IDW'(NREQ - 1);
            target_q  <= {CW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            grant_q   <= {NREQ{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= {IDW{1'b0}};
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_ptr_q  <= rr_ptr_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.q       = cnt_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_rcc_interval_arbiter.sv
// Scoreboard bench for rcc_interval_arbiter: a transaction-level model predicts each completion.
module tb_rcc_interval_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rcc_interval_arbiter_if #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) bus ();

    rcc_interval_arbiter #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int ab;
        int q;
        int edge_n;
    } exp_t;

    exp_t sbq[$];

    // Reference model: one interval at a time, measured in edges since the grant edge.
    int  edge_n = 0;
    bit  m_act  = 1'b0;
    bit  m_ended;
    int  m_id, m_tgt, m_t, m_end;
    int  m_rr = NREQ - 1;
    int  w;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic void finish_interval(input int ab, input int qv);
        exp_t e;
        e.id = m_id; e.ab = ab; e.q = qv; e.edge_n = edge_n;
        sbq.push_back(e);
        m_ended = 1'b1;
        m_end   = m_t;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act = 1'b0;
            m_rr  = NREQ - 1;
            sbq.delete();
        end else begin
            edge_n++;
            if (m_act) begin
                m_t++;
                if (!m_ended) begin
                    if (m_tgt == 0) begin
                        if (m_t == 1) finish_interval(0, 0);
                    end else if (m_t >= 2 && !bus.req[m_id]) begin
                        finish_interval(1, m_t - 2);
                    end else if (m_t == m_tgt + 1) begin
                        finish_interval(0, m_tgt);
                    end
                end else if (m_t == m_end + 1) begin
                    m_act = 1'b0;
                    m_rr  = m_id;
                end
            end else begin
                w = rr_pick(bus.req, m_rr);
                if (w >= 0) begin
                    m_act   = 1'b1;
                    m_id    = w;
                    m_tgt   = int'(bus.len[w*CW +: CW]);
                    m_t     = 0;
                    m_ended = 1'b0;
                end
            end
        end
    end

    // Monitor: per-cycle grant/busy against the model, and scoreboard pop on every done.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("busy", int'(bus.busy), int'(m_act));
            check("grant", int'(bus.grant), m_act ? (1 << m_id) : 0);
            if (sbq.size() > 0 && sbq[0].edge_n < edge_n) begin
                e = sbq.pop_front();
                total++; bad++;
                $display("FAIL missed_done: no done seen, expected id %0d at edge %0d", e.id, e.edge_n);
            end
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got id %0d, expected no done", bus.done_id);
                end else begin
                    e = sbq.pop_front();
                    check("done_id", int'(bus.done_id), e.id);
                    check("aborted", int'(bus.aborted), e.ab);
                    check("q_at_done", int'(bus.q), e.q);
                    check("done_edge", edge_n, e.edge_n);
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 200);
        if (!bus.done) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_q(input int val, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.busy && int'(bus.q) == val) && n < 200);
        if (int'(bus.q) != val) check({name, "_timeout"}, int'(bus.q), val);
    endtask

    initial begin
        reset   = 1'b0;
        bus.req = 4'b1111;
        bus.len = {4{4'd2}};
        #14;
        check("rst_grant", int'(bus.grant), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_q", int'(bus.q), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("first_grant", int'(bus.grant), 1);

        // Round-robin with all requesters held and len=2 each
        repeat (25) @(negedge clk);
        bus.req = 4'b0000;
        wait_idle("rr_idle");
        @(negedge clk);

        // Single request, length 5
        bus.req = 4'b0100;
        bus.len = 16'h0500;
        @(negedge clk);
        check("single_grant", int'(bus.grant), 4);
        wait_done("single");
        check("single_q", int'(bus.q), 5);
        bus.req = 4'b0000;
        wait_idle("single_idle");

        // Zero length
        bus.req = 4'b0010;
        bus.len = 16'h0000;
        wait_done("zero");
        bus.req = 4'b0000;
        wait_idle("zero_idle");

        // Abort after q=3
        bus.req = 4'b0001;
        bus.len = 16'h000A;
        wait_q(3, "abort_q");
        bus.req = 4'b0000;
        wait_done("abort");
        check("abort_flag", int'(bus.aborted), 1);
        check("abort_q_frozen", int'(bus.q), 3);
        wait_idle("abort_idle");

        // Mid-run asynchronous reset
        bus.req = 4'b0001;
        wait_q(6, "midrst_q");
        #2 reset = 1'b0;
        #1;
        check("midrst_grant", int'(bus.grant), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_q", int'(bus.q), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_done_id", int'(bus.done_id), 0);
        check("midrst_aborted", int'(bus.aborted), 0);
        bus.req = 4'b1000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_first_grant", int'(bus.grant), 8);
        wait_done("midrst");
        bus.req = 4'b0000;
        wait_idle("midrst_idle");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom());
            if ($urandom_range(0, 3) == 0) bus.len = 16'($urandom());
        end
        bus.req = 4'b0000;
        wait_idle("final_idle");
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
